ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a command-word RAM port.
// A granted transaction issues an address word and a data word on ram_din, waits
// for read data when it is a read, then pulses the requester's done.
// Optional feature: define RAM_ARB_TIMEOUT_EN to abort reads that stay in RDWAIT
// for TIMEOUT_CYC cycles without ram_tx_valid (done with err=1, rdata unchanged).
module ram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       err,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  // Elaboration-time guard on the timeout range.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("ram_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RDWAIT,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;    // last granted requester (1 => req0 wins a tie)
  logic       sel_q, sel_d;      // requester owning the current transaction
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic [7:0] rdata_q, rdata_d;
  logic [9:0] ram_din_q, ram_din_d;
  logic       ram_rx_valid_q, ram_rx_valid_d;
  logic       pick;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // Next-state and next-output logic; outputs lag the state by one cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d        = state_q;
    last_d         = last_q;
    sel_d          = sel_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    gnt0_d         = 1'b0;
    gnt1_d         = 1'b0;
    done0_d        = 1'b0;
    done1_d        = 1'b0;
    ram_din_d      = 10'h000;
    ram_rx_valid_d = 1'b0;
    pick           = (req0 && req1) ? ~last_q : req1;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_d          = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1    : we0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = S_ADDR;
`ifdef RAM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        ram_rx_valid_d = 1'b1;
        ram_din_d      = {(we_q ? 2'b00 : 2'b10), addr_q};
        state_d        = S_DATA;
      end
      S_DATA: begin
        ram_rx_valid_d = 1'b1;
        ram_din_d      = we_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
        state_d        = we_q ? S_DONE : S_RDWAIT;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt_d          = 8'h00;
`endif
      end
      S_RDWAIT: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          state_d = S_DONE;
`ifdef RAM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'h01;
`endif
        end
      end
      S_DONE: begin
        done0_d = ~sel_q;
        done1_d = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_q         <= 1'b1;
      sel_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      done0_q        <= 1'b0;
      done1_q        <= 1'b0;
      rdata_q        <= 8'h00;
      ram_din_q      <= 10'h000;
      ram_rx_valid_q <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q          <= 8'h00;
      err_q          <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      last_q         <= last_d;
      sel_q          <= sel_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      gnt0_q         <= gnt0_d;
      gnt1_q         <= gnt1_d;
      done0_q        <= done0_d;
      done1_q        <= done1_d;
      rdata_q        <= rdata_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata        = rdata_q;
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
`ifdef RAM_ARB_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus randomized transactions checked against a
// transaction-level model (RAM array, last-granted requester, last read data).
// Cycle k is the k-th falling edge after the edge that samples a request.
module tb_ram_arbiter;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata;
  logic       err;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  typedef struct {
    bit         pend;
    bit         we;
    logic [7:0] a;
    logic [7:0] d;
  } rq_t;

  logic [7:0] mem [256];
  rq_t        rq [2];
  int         exp_last;
  logic [7:0] exp_rdata;
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    req0 = rq[0].pend; we0 = rq[0].we; addr0 = rq[0].a; wdata0 = rq[0].d;
    req1 = rq[1].pend; we1 = rq[1].we; addr1 = rq[1].a; wdata1 = rq[1].d;
  endtask

  task automatic new_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    rq[i].pend = 1'b1; rq[i].we = we; rq[i].a = a; rq[i].d = d;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    check({tag, "_done"}, {30'd0, done1, done0}, 32'd0);
    check({tag, "_rxv"}, {31'd0, ram_rx_valid}, 32'd0);
    check({tag, "_din"}, {22'd0, ram_din}, 32'd0);
  endtask

  task automatic idle(input int n);
    drive_reqs();
    for (int i = 0; i < n; i++) begin
      ram_tx_valid = 1'($urandom);
      ram_dout     = 8'($urandom);
      @(negedge clk);
      check_quiet("idle");
    end
    ram_tx_valid = 1'b0;
  endtask

  // Serve one transaction. dly: cycles the RAM waits before answering a read;
  // dly < 0 means it never answers. glitch: briefly pulse the other req mid-way.
  task automatic serve(input int dly, input bit glitch);
    int         w, done_k;
    bit         rd, tmo;
    logic [7:0] a, d;
    logic [9:0] exp_din;
    w   = (rq[0].pend && rq[1].pend) ? 1 - exp_last : (rq[1].pend ? 1 : 0);
    rd  = !rq[w].we;
    a   = rq[w].a;
    d   = rq[w].d;
    tmo = 1'b0;
    if (!rd) done_k = 4;
    else if (dly >= 0) done_k = 5 + dly;
    else begin
`ifdef RAM_ARB_TIMEOUT_EN
      done_k = 4 + TO;
      tmo    = 1'b1;
`else
      done_k = 200;
      check("no_answer_without_timeout", 32'd1, 32'd0);
`endif
    end
    drive_reqs();
    ram_tx_valid = 1'b0;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      check("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      check("gnt0", {31'd0, gnt0}, {31'd0, k == 1 && w == 0});
      check("gnt1", {31'd0, gnt1}, {31'd0, k == 1 && w == 1});
      if (k == 1) begin
        rq[w].pend = 1'b0;
        exp_last   = w;
        drive_reqs();
      end
      check("rx_valid", {31'd0, ram_rx_valid}, {31'd0, k == 2 || k == 3});
      if (k == 2)      exp_din = {(rd ? 2'b10 : 2'b00), a};
      else if (k == 3) exp_din = rd ? 10'h300 : {2'b01, d};
      else             exp_din = 10'h000;
      check("ram_din", {22'd0, ram_din}, {22'd0, exp_din});
      check("done0", {31'd0, done0}, {31'd0, k == done_k && w == 0});
      check("done1", {31'd0, done1}, {31'd0, k == done_k && w == 1});
      if (k == done_k) begin
        if (!rd) begin
          mem[a]  = d;
          exp_err = 1'b0;
        end else if (tmo) begin
          exp_err = 1'b1;
        end else begin
          exp_rdata = mem[a];
          exp_err   = 1'b0;
        end
        check("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
        check("err", {31'd0, err}, {31'd0, exp_err});
      end
      if (glitch && !rq[1-w].pend) begin
        if (k == 2) begin
          if (w == 0) req1 = 1'b1; else req0 = 1'b1;
        end else if (k == 3) begin
          drive_reqs();
        end
      end
      if (rd && dly >= 0 && k == 3 + dly) begin
        ram_tx_valid = 1'b1;
        ram_dout     = mem[a];
      end else if (k <= (rd ? 2 : 3)) begin
        ram_tx_valid = 1'($urandom);
        ram_dout     = 8'($urandom);
      end else begin
        ram_tx_valid = 1'b0;
      end
    end
    ram_tx_valid = 1'b0;
  endtask

  task automatic refill_random(input int prob_pct);
    for (int i = 0; i < 2; i++)
      if (!rq[i].pend && int'($urandom_range(99)) < prob_pct)
        new_req(i, 1'($urandom), 8'($urandom_range(15)), 8'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      rq[i].pend = 1'b0; rq[i].we = 1'b0; rq[i].a = 8'h00; rq[i].d = 8'h00;
    end
    exp_last = 1; exp_rdata = 8'h00; exp_err = 1'b0;
    ram_tx_valid = 1'b0; ram_dout = 8'h00;
    drive_reqs();

    // Reset state
    rst = 1'b1;
    #1;
    check_quiet("reset");
    check("reset_rdata", {24'd0, rdata}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Write then read-after-write at the same address
    new_req(0, 1'b1, 8'h3C, 8'hA5);
    serve(0, 1'b0);
    new_req(1, 1'b0, 8'h3C, 8'h00);
    serve(2, 1'b0);
    check("raw_rdata", {24'd0, rdata}, 32'h0000_00A5);

    // Contention: both held high, grants alternate
    for (int t = 0; t < 4; t++) begin
      refill_random(100);
      serve(int'($urandom_range(3)), 1'b0);
    end
    serve(0, 1'b0);
    idle(1);

    // A req that drops before it can be sampled in IDLE is ignored
    new_req(1, 1'b1, 8'h07, 8'h5A);
    serve(0, 1'b1);
    idle(3);

    // Unanswered read: timeout when enabled, indefinite wait otherwise
    new_req(1, 1'b0, 8'h3C, 8'h00);
`ifdef RAM_ARB_TIMEOUT_EN
    serve(-1, 1'b0);
`else
    serve(40, 1'b0);
`endif
    idle(1);

    // Reset during RDWAIT of a req0 read, then a tie must go to req0
    new_req(0, 1'b0, 8'h3C, 8'h00);
    drive_reqs();
    @(negedge clk);
    check("rst_gnt0", {31'd0, gnt0}, 32'd1);
    rq[0].pend = 1'b0;
    drive_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    check("rst_mid_rdata", {24'd0, rdata}, 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check_quiet("rst_hold");
    rst = 1'b0;
    exp_last = 1; exp_rdata = 8'h00; exp_err = 1'b0;
    new_req(0, 1'b1, 8'h10, 8'h11);
    new_req(1, 1'b1, 8'h20, 8'h22);
    serve(0, 1'b0);
    serve(0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      refill_random(60);
      if (!rq[0].pend && !rq[1].pend) idle(1 + int'($urandom_range(1)));
      else serve(int'($urandom_range(4)), 1'b0);
    end
    while (rq[0].pend || rq[1].pend) serve(0, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
